// File: rtl/pc_gen_unit.sv
// Fetch PC register with IMEM valid/ready handshake and a PC/valid delay line out to EXE.
// Optional macro PC_GEN_MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VEC.
module pc_gen_unit #(
  parameter int                DATA_W      = 32,
  parameter int                INSTR_BYTES = 4,
  parameter int                STAGES      = 3,
  parameter logic [DATA_W-1:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [DATA_W-1:0] TRAP_VEC    = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  output logic [DATA_W-1:0] pc_o,
  input  logic              stall_i,
  input  logic              jump_taken_i,
  input  logic              jalr_i,
  input  logic [DATA_W-1:0] jalr_base_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] target_o,
  output logic              flush_o,
  output logic [DATA_W-1:0] pc_exe_o,
  output logic [DATA_W-1:0] link_o,
  output logic              exe_valid_o,
  output logic              misalign_o
);
  localparam int OFF_W = $clog2(INSTR_BYTES);

  // Fetch handshake: a request is offered whenever fetch_valid_o is high and is
  // accepted on a rising edge where fetch_ready_i is also high; pc_o stays stable
  // until then. Acceptance is ignored (no advance) while stall_i holds the pipe.
  logic [DATA_W-1:0] pc_q;
  logic              fetch_valid_q;
  logic [DATA_W-1:0] pipe_pc [STAGES];
  logic [STAGES-1:0] pipe_vld;

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] load_pc;
  logic              redirect;
  logic              accept;

  assign base = jalr_i ? jalr_base_i : pipe_pc[STAGES-1];

  always_comb begin
    target = base + imm_i;
    if (jalr_i) target[0] = 1'b0;
  end

  assign redirect = jump_taken_i & pipe_vld[STAGES-1];
  assign accept   = fetch_valid_q & fetch_ready_i;

`ifdef PC_GEN_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q;
  assign misaligned = |target[OFF_W-1:0];
  assign load_pc    = misaligned ? TRAP_VEC : target;
  assign misalign_o = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= redirect & misaligned;
  end
`else
  assign load_pc    = {target[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VEC;
      fetch_valid_q <= 1'b0;
      pipe_vld      <= '0;
      for (int k = 0; k < STAGES; k++) pipe_pc[k] <= '0;
    end else begin
      fetch_valid_q <= 1'b1;
      if (redirect) begin
        // The EXE instruction retires; everything younger, including a fetch
        // accepted this cycle, is dropped.
        pc_q       <= load_pc;
        pipe_pc[0] <= pc_q;
        for (int k = 1; k < STAGES; k++) pipe_pc[k] <= pipe_pc[k-1];
        pipe_vld   <= '0;
      end else if (!stall_i) begin
        if (accept) pc_q <= pc_q + DATA_W'(INSTR_BYTES);
        pipe_pc[0] <= pc_q;
        for (int k = 1; k < STAGES; k++) pipe_pc[k] <= pipe_pc[k-1];
        pipe_vld   <= {pipe_vld[STAGES-2:0], accept};
      end
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign pc_o          = pc_q;
  assign target_o      = target;
  assign flush_o       = redirect;
  assign pc_exe_o      = pipe_pc[STAGES-1];
  assign link_o        = pipe_pc[STAGES-1] + DATA_W'(INSTR_BYTES);
  assign exe_valid_o   = pipe_vld[STAGES-1];
endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: target-computation vector table, directed pipeline
// sequences and a fetch-to-EXE scoreboard queue.
module tb_pc_gen_unit;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid_o;
  logic        fetch_ready = 1'b0;
  logic [31:0] pc_o;
  logic        stall = 1'b0;
  logic        jump_taken = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] jalr_base = '0;
  logic [31:0] imm = '0;
  logic [31:0] target_o;
  logic        flush_o;
  logic [31:0] pc_exe_o;
  logic [31:0] link_o;
  logic        exe_valid_o;
  logic        misalign_o;

  pc_gen_unit dut (
    .clk(clk), .rst(rst),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready), .pc_o(pc_o),
    .stall_i(stall), .jump_taken_i(jump_taken), .jalr_i(jalr),
    .jalr_base_i(jalr_base), .imm_i(imm), .target_o(target_o), .flush_o(flush_o),
    .pc_exe_o(pc_exe_o), .link_o(link_o), .exe_valid_o(exe_valid_o),
    .misalign_o(misalign_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;

`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc  = RESET_VEC;
  logic        exp_fv  = 1'b0;
  logic        exp_mis = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: score the current cycle before the edge, then advance.
  task automatic tick();
    logic        redir;
    logic        next_mis;
    logic [31:0] exp_exe;
    logic [31:0] t;
    next_mis = 1'b0;
    exp_exe  = '0;
    @(negedge clk);
    if (!rst) begin
      chk("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, exp_fv});
      chk("pc_o", pc_o, exp_pc);
      chk("misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
      redir = jump_taken && exe_valid_o;
      if (exe_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL exe_spurious: got valid pc %h expected no instruction", pc_exe_o);
        end else begin
          exp_exe = exp_q[0];
          chk("pc_exe", pc_exe_o, exp_exe);
          chk("link", link_o, exp_exe + 32'd4);
          if (!stall || redir) void'(exp_q.pop_front());
        end
      end
      chk("flush", {31'b0, flush_o}, {31'b0, redir});
      if (redir) begin
        t = (jalr ? jalr_base : exp_exe) + imm;
        if (jalr) t[0] = 1'b0;
        chk("target", target_o, t);
        exp_q.delete();
        if (TRAP_EN && t[1:0] != 2'b00) begin
          exp_pc   = TRAP_VEC;
          next_mis = 1'b1;
        end else begin
          exp_pc = t & 32'hFFFF_FFFC;
        end
      end else if (!stall && fetch_valid_o && fetch_ready) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_pc  = RESET_VEC;
      exp_fv  = 1'b0;
      exp_mis = 1'b0;
    end else begin
      exp_fv  = 1'b1;
      exp_mis = next_mis;
    end
    #1;
  endtask

  task automatic wait_exe(input string name, input logic [31:0] want_pc, input logic any_pc);
    int n;
    n = 0;
    while (!(exe_valid_o && (any_pc || pc_exe_o == want_pc)) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got no EXE instruction expected pc %h", name, want_pc);
    end
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] exp;
  } tgt_vec_t;

  tgt_vec_t vec[6];

  initial begin
    int acc_at;
    int exe_at;
    int n;

    vec[0] = '{32'h0000_1001, 32'h0000_0004, 32'h0000_1004};
    vec[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vec[2] = '{32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0000};
    vec[3] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFE};
    vec[4] = '{32'h8000_0000, 32'h8000_0001, 32'h0000_0000};
    vec[5] = '{32'h0000_1234, 32'h0000_0010, 32'h0000_1244};

    // reset, with the combinational JALR target table applied meanwhile
    tick();
    jalr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      jalr_base = vec[i].base;
      imm       = vec[i].imm;
      #1;
      chk($sformatf("tgt_vec%0d", i), target_o, vec[i].exp);
    end
    jalr = 1'b0; jalr_base = '0; imm = '0;
    tick();
    chk("rst_pc", pc_o, RESET_VEC);
    chk("rst_fetch_valid", {31'b0, fetch_valid_o}, 32'd0);
    chk("rst_exe_valid", {31'b0, exe_valid_o}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'd0);

    // sequential fetch and first-instruction latency
    rst = 1'b0;
    fetch_ready = 1'b1;
    acc_at = -1;
    exe_at = -1;
    for (int i = 0; i < 5; i++) begin
      if (acc_at < 0 && fetch_valid_o && fetch_ready) acc_at = i;
      if (exe_at < 0 && exe_valid_o) exe_at = i;
      tick();
    end
    chk("first_exe_latency", exe_at - acc_at, 32'd3);

    // backpressure at 0x10
    n = 0;
    while (pc_o != 32'h10 && n < 20) begin tick(); n++; end
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_hold", pc_o, 32'h10);
    fetch_ready = 1'b1;
    tick();
    chk("bp_resume", pc_o, 32'h14);

    // branch redirect from EXE pc 0x20 with a simultaneous stall
    wait_exe("br", 32'h20, 1'b0);
    jump_taken = 1'b1; imm = 32'hFFFF_FFF0; stall = 1'b1;
    #1;
    chk("br_target", target_o, 32'h10);
    chk("br_flush", {31'b0, flush_o}, 32'd1);
    tick();
    jump_taken = 1'b0; stall = 1'b0; imm = '0;
    chk("br_pc", pc_o, 32'h10);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("br_bubble%0d", i), {31'b0, exe_valid_o}, 32'd0);
      tick();
    end
    chk("br_exe_valid", {31'b0, exe_valid_o}, 32'd1);
    chk("br_exe_pc", pc_exe_o, 32'h10);

    // JALR, then a jump request with no live EXE instruction
    jalr = 1'b1; jalr_base = 32'h1001; imm = 32'h4; jump_taken = 1'b1;
    #1;
    chk("jalr_target", target_o, 32'h1004);
    chk("jalr_link", link_o, 32'h14);
    tick();
    jalr = 1'b0; imm = 32'h40;
    chk("ign_exe_valid", {31'b0, exe_valid_o}, 32'd0);
    chk("ign_flush", {31'b0, flush_o}, 32'd0);
    tick();
    jump_taken = 1'b0; imm = '0;
    chk("ign_pc", pc_o, 32'h1008);

    // address wrap
    wait_exe("wrap", '0, 1'b1);
    jalr = 1'b1; jalr_base = 32'hFFFF_FFF8; imm = 32'h4; jump_taken = 1'b1;
    tick();
    jalr = 1'b0; jump_taken = 1'b0; imm = '0;
    chk("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_zero", pc_o, 32'h0);
    wait_exe("wrap_exe", 32'hFFFF_FFFC, 1'b0);
    chk("wrap_link", link_o, 32'h0);

    // misaligned target 0x102
    jalr = 1'b1; jalr_base = 32'h100; imm = 32'h2; jump_taken = 1'b1;
    tick();
    jalr = 1'b0; jump_taken = 1'b0; imm = '0;
    chk("mis_pc", pc_o, 32'h100);
    chk("mis_pulse", {31'b0, misalign_o}, {31'b0, TRAP_EN});
    tick();
    chk("mis_pulse_end", {31'b0, misalign_o}, 32'd0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      fetch_ready = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      jump_taken  = ($urandom_range(0, 7) == 0);
      jalr        = ($urandom_range(0, 1) == 1);
      jalr_base   = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      imm         = {24'b0, 6'($urandom_range(0, 63)), 2'b00} - 32'h80;
      tick();
    end
    stall = 1'b0; jump_taken = 1'b0; jalr = 1'b0; fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // reset mid-operation overrides redirect and stall
    wait_exe("mid", '0, 1'b1);
    rst = 1'b1; jump_taken = 1'b1; stall = 1'b1; imm = 32'h40;
    tick();
    rst = 1'b0; jump_taken = 1'b0; stall = 1'b0; imm = '0;
    chk("mid_rst_pc", pc_o, RESET_VEC);
    chk("mid_rst_exe_valid", {31'b0, exe_valid_o}, 32'd0);
    chk("mid_rst_fetch_valid", {31'b0, fetch_valid_o}, 32'd0);
    for (int i = 0; i < 6; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
